// File: rtl/array_alloc_arbiter.sv
// Round-robin arbitrated allocator for a pool of NArrays handles. Freed
// handles are recycled LIFO before untouched ones are handed out.
module array_alloc_arbiter #(
  parameter int MemoryElementWidth = 12,
  parameter int NArrays            = 8,
  parameter int NReq               = 2
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NReq-1:0]                    reqValid,
  input  logic [NReq-1:0]                    reqFree,
  input  logic [NReq*MemoryElementWidth-1:0] reqArray,
  output logic [NReq-1:0]                    reqReady,
  output logic                               respValid,
  output logic [MemoryElementWidth-1:0]      respArray,
  output logic                               respError,
  output logic [MemoryElementWidth-1:0]      allocs,
  output logic [MemoryElementWidth-1:0]      maxAllocs
);

  localparam int W     = MemoryElementWidth;
  localparam int AW    = (NArrays > 1) ? $clog2(NArrays) : 1;
  localparam int IW    = (NReq > 1) ? $clog2(NReq) : 1;
  localparam int Depth = 1 << AW;
  localparam logic [W-1:0] NArraysW = W'(NArrays);

  typedef enum logic [1:0] {INIT, IDLE, EXEC, RESP} state_t;
  state_t state_reg, state_next;

  logic [AW-1:0]    init_cnt_reg;
  logic [IW-1:0]    last_reg, win_idx_reg;
  logic             win_free_reg;
  logic [W-1:0]     win_handle_reg;
  logic [W-1:0]     next_fresh_reg, sp_reg, allocs_reg, max_allocs_reg;
  logic [W-1:0]     resp_array_reg, top_reg;
  logic             resp_error_reg;
  logic [Depth-1:0] in_use_reg;
  logic [W-1:0]     stack_mem [Depth];

  logic [W-1:0]     req_handle [NReq];
  logic             pick_found;
  logic [IW-1:0]    pick_idx, cand;
  logic             exec_ok, exec_push, exec_pop, exec_fresh;
  logic [W-1:0]     exec_handle, allocs_next;

  generate
    for (genvar gi = 0; gi < NReq; gi++) begin : g_unpack
      assign req_handle[gi] = reqArray[gi*W +: W];
    end
  endgenerate

  // Scan from farthest to nearest so the first valid index after last_reg wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last_reg;
    cand       = last_reg;
    for (int k = NReq; k >= 1; k--) begin
      cand = IW'((int'(last_reg) + k) % NReq);
      if (reqValid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state_reg <= INIT;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      INIT:    if (init_cnt_reg == AW'(NArrays - 1)) state_next = IDLE;
      IDLE:    if (pick_found) state_next = EXEC;
      EXEC:    state_next = RESP;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NReq; i++) begin
      reqReady[i] = (state_reg == EXEC) && (win_idx_reg == IW'(i));
    end
    respValid = (state_reg == RESP);
    respError = (state_reg == RESP) && resp_error_reg;
  end

  always_comb begin
    exec_ok     = 1'b0;
    exec_push   = 1'b0;
    exec_pop    = 1'b0;
    exec_fresh  = 1'b0;
    exec_handle = win_handle_reg;
    if (win_free_reg) begin
      if (win_handle_reg < next_fresh_reg && in_use_reg[win_handle_reg[AW-1:0]]) begin
        exec_ok   = 1'b1;
        exec_push = 1'b1;
      end
    end else if (sp_reg != '0) begin
      exec_ok     = 1'b1;
      exec_pop    = 1'b1;
      exec_handle = top_reg;
    end else if (next_fresh_reg < NArraysW) begin
      exec_ok     = 1'b1;
      exec_fresh  = 1'b1;
      exec_handle = next_fresh_reg;
    end else begin
      exec_handle = '0;
    end
    allocs_next = allocs_reg;
    if (exec_ok) allocs_next = win_free_reg ? allocs_reg - W'(1) : allocs_reg + W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      init_cnt_reg   <= '0;
      next_fresh_reg <= '0;
      sp_reg         <= '0;
      allocs_reg     <= '0;
      max_allocs_reg <= '0;
      resp_array_reg <= '0;
      resp_error_reg <= 1'b0;
      last_reg       <= IW'(NReq - 1);
    end else begin
      case (state_reg)
        INIT: init_cnt_reg <= init_cnt_reg + AW'(1);
        IDLE: begin
          if (pick_found) begin
            win_idx_reg    <= pick_idx;
            win_free_reg   <= reqFree[pick_idx];
            win_handle_reg <= req_handle[pick_idx];
          end
        end
        EXEC: begin
          last_reg       <= win_idx_reg;
          if (exec_pop)   sp_reg <= sp_reg - W'(1);
          if (exec_push)  sp_reg <= sp_reg + W'(1);
          if (exec_fresh) next_fresh_reg <= next_fresh_reg + W'(1);
          allocs_reg     <= allocs_next;
          if (allocs_next > max_allocs_reg) max_allocs_reg <= allocs_next;
          resp_array_reg <= exec_handle;
          resp_error_reg <= !exec_ok;
        end
        default: ;
      endcase
    end
  end

  // Top of stack is read one cycle ahead; the stack only changes in EXEC.
  always_ff @(posedge clock) begin
    top_reg <= stack_mem[sp_reg[AW-1:0] - AW'(1)];
    if (state_reg == EXEC && exec_push) stack_mem[sp_reg[AW-1:0]] <= win_handle_reg;
  end

  always_ff @(posedge clock) begin
    if (state_reg == INIT) begin
      in_use_reg[init_cnt_reg] <= 1'b0;
    end else if (state_reg == EXEC && !reset) begin
      if (exec_push) in_use_reg[win_handle_reg[AW-1:0]] <= 1'b0;
      if (exec_ok && !win_free_reg) in_use_reg[exec_handle[AW-1:0]] <= 1'b1;
    end
  end

  assign respArray = resp_array_reg;
  assign allocs    = allocs_reg;
  assign maxAllocs = max_allocs_reg;

endmodule

// File: tb/tb_array_alloc_arbiter.sv
// Directed and random checks of array_alloc_arbiter (NArrays=4, NReq=2)
// against a queue-based allocator model.
module tb_array_alloc_arbiter;
  localparam int W  = 12;
  localparam int NA = 4;
  localparam int NR = 2;

  logic            clock = 1'b0;
  logic            reset;
  logic [NR-1:0]   reqValid, reqFree, reqReady;
  logic [NR*W-1:0] reqArray;
  logic            respValid, respError;
  logic [W-1:0]    respArray, allocs, maxAllocs;

  array_alloc_arbiter #(.MemoryElementWidth(W), .NArrays(NA), .NReq(NR)) dut (
    .clock(clock), .reset(reset), .reqValid(reqValid), .reqFree(reqFree),
    .reqArray(reqArray), .reqReady(reqReady), .respValid(respValid),
    .respArray(respArray), .respError(respError), .allocs(allocs),
    .maxAllocs(maxAllocs)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  int m_stack[$];
  bit m_used[NA];
  int m_fresh, m_allocs, m_max, m_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_stack.delete();
    for (int i = 0; i < NA; i++) m_used[i] = 1'b0;
    m_fresh  = 0;
    m_allocs = 0;
    m_max    = 0;
    m_last   = NR - 1;
  endtask

  task automatic model_op(input bit fr, input int h, output int arr, output bit err);
    arr = 0;
    err = 1'b1;
    if (fr) begin
      arr = h;
      if (h < m_fresh && m_used[h]) begin
        m_used[h] = 1'b0;
        m_stack.push_back(h);
        m_allocs--;
        err = 1'b0;
      end
    end else if (m_stack.size() > 0) begin
      arr = m_stack.pop_back();
      m_used[arr] = 1'b1;
      m_allocs++;
      err = 1'b0;
    end else if (m_fresh < NA) begin
      arr = m_fresh;
      m_fresh++;
      m_used[arr] = 1'b1;
      m_allocs++;
      err = 1'b0;
    end
    if (m_allocs > m_max) m_max = m_allocs;
  endtask

  // Returns the number of samples with reqReady low; the current sample counts.
  task automatic wait_ready(output int waited);
    waited = 0;
    while (reqReady === '0 && waited < 50) begin
      waited++;
      @(negedge clock);
    end
  endtask

  // Entered on the EXEC sample; leaves on the IDLE sample after RESP.
  task automatic check_resp(input string tag, input int exp_arr, input bit exp_err);
    check({tag, " respValid_in_exec"}, respValid, 0);
    @(negedge clock);
    check({tag, " respValid"}, respValid, 1);
    check({tag, " respArray"}, respArray, exp_arr);
    check({tag, " respError"}, respError, exp_err);
    check({tag, " allocs"}, allocs, m_allocs);
    check({tag, " maxAllocs"}, maxAllocs, m_max);
    check({tag, " reqReady_in_resp"}, reqReady, 0);
    @(negedge clock);
    check({tag, " respValid_after"}, respValid, 0);
  endtask

  task automatic run_op(input int r, input bit fr, input int h, input string tag);
    int w, arr;
    bit err;
    reqFree[r] = fr;
    reqArray[r*W +: W] = W'(h);
    reqValid[r] = 1'b1;
    wait_ready(w);
    check({tag, " reqReady"}, reqReady, 1 << r);
    reqValid[r] = 1'b0;
    model_op(fr, h, arr, err);
    m_last = r;
    check_resp(tag, arr, err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w, arr, prev, exp_r;
    bit err;
    reset    = 1'b1;
    reqValid = '0;
    reqFree  = '0;
    reqArray = '0;
    model_reset();
    repeat (3) @(negedge clock);
    check("reset reqReady", reqReady, 0);
    check("reset respValid", respValid, 0);
    check("reset respError", respError, 0);
    check("reset respArray", respArray, 0);
    check("reset allocs", allocs, 0);
    check("reset maxAllocs", maxAllocs, 0);

    // Request pending from INIT: 4 INIT samples plus the IDLE pick, then EXEC.
    reset      = 1'b0;
    reqFree[0] = 1'b0;
    reqValid[0] = 1'b1;
    wait_ready(w);
    check("init idle samples", w, NA + 1);
    check("first accept reqReady", reqReady, 1);
    reqValid[0] = 1'b0;
    model_op(1'b0, 0, arr, err);
    m_last = 0;
    check_resp("alloc#1", arr, err);
    check("alloc#1 handle", respArray, 0);

    run_op(0, 1'b0, 0, "alloc#2");
    run_op(0, 1'b0, 0, "alloc#3");
    check("after 3 allocs allocs", allocs, 3);
    check("after 3 allocs maxAllocs", maxAllocs, 3);

    run_op(0, 1'b1, 1, "free1");
    run_op(0, 1'b0, 0, "lifo alloc");
    check("lifo handle", respArray, 1);
    check("lifo allocs", allocs, 3);

    run_op(0, 1'b0, 0, "alloc#4");
    run_op(0, 1'b0, 0, "alloc full");
    check("full allocs", allocs, 4);
    run_op(0, 1'b1, 3, "free3");
    run_op(0, 1'b1, 3, "double free3");
    run_op(0, 1'b1, 7, "free7");
    check("free7 maxAllocs", maxAllocs, 4);

    for (int n = 0; n < 40; n++) begin
      run_op($urandom_range(0, NR - 1), 1'($urandom_range(0, 1)),
             $urandom_range(0, NA + 1), "random");
    end

    // Fresh reset, then both requesters contend continuously.
    reset = 1'b1;
    repeat (2) @(negedge clock);
    model_reset();
    reset    = 1'b0;
    reqFree  = '0;
    reqValid = '1;
    prev     = 0;
    for (int n = 0; n < 4; n++) begin
      wait_ready(w);
      exp_r = (m_last + 1) % NR;
      check("rr grant", reqReady, 1 << exp_r);
      if (n > 0) check("rr spacing", cyc - prev, 3);
      prev = cyc;
      model_op(1'b0, 0, arr, err);
      m_last = exp_r;
      if (n == 3) reqValid = '0;
      check_resp("rr alloc", arr, err);
    end

    // Reset during EXEC drops the operation; the pending request retries.
    reqFree[0]  = 1'b0;
    reqValid[0] = 1'b1;
    wait_ready(w);
    check("abort accept", reqReady, 1);
    reset = 1'b1;
    @(negedge clock);
    check("abort respValid", respValid, 0);
    check("abort allocs", allocs, 0);
    check("abort reqReady", reqReady, 0);
    @(negedge clock);
    check("abort respValid2", respValid, 0);
    model_reset();
    reset = 1'b0;
    wait_ready(w);
    check("retry wait", w, NA + 1);
    check("retry accept", reqReady, 1);
    reqValid[0] = 1'b0;
    model_op(1'b0, 0, arr, err);
    m_last = 0;
    check_resp("retry alloc", arr, err);
    check("retry handle", respArray, 0);
    check("retry allocs", allocs, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
